instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/if_pkg.sv | 17 +
 rtl/if_btfn_pred.sv | 28 ++
 rtl/instr_fetch.sv | 138 +++++++++++++
 tb/tb_instr_fetch.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// if_pkg: shared types and constants for the instruction fetch unit.
// Contents: fetch FSM state encoding, beq/bne opcodes, default reset PC.
package if_pkg;

    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_REQ   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_VALID = 3'd3,
        ST_HALT  = 3'd4
    } if_state_e;

    localparam logic [5:0]  OPC_BEQ          = 6'h04;
    localparam logic [5:0]  OPC_BNE          = 6'h05;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

endpackage

// File: rtl/if_btfn_pred.sv
// if_btfn_pred: backward-taken/forward-not-taken next-PC predictor (combinational).
// Ports: instr - captured instruction word; pc - its address;
//        next_pc - branch target for backward beq/bne, otherwise pc+4.
// Instantiated by instr_fetch only when IF_BTFN_PREDICT_EN is defined.
module if_btfn_pred
    import if_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    output logic [31:0] next_pc
);

    logic [31:0] seq_pc;
    logic [31:0] br_pc;
    logic        taken;
    logic        unused_instr_bits;

    assign unused_instr_bits = ^instr[25:16];

    always_comb begin
        seq_pc  = pc + 32'd4;
        br_pc   = seq_pc + {{14{instr[15]}}, instr[15:0], 2'b00};
        // Only a negative displacement (backward branch) is predicted taken.
        taken   = (instr[31:26] == OPC_BEQ || instr[31:26] == OPC_BNE) && instr[15];
        next_pc = taken ? br_pc : seq_pc;
    end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding-request instruction fetch unit feeding a decode queue.
// Ports: CLK/RESET (async, active-high); SYS flush; STALL_IN decode backpressure;
//        REDIRECT_VALID/REDIRECT_PC redirect; IMEM_REQ/IMEM_ADDR/IMEM_ACK/IMEM_RDATA
//        memory handshake; Instr_OUT/Instr_PC_OUT/STALL_OUT decode-side output.
// Option: define IF_BTFN_PREDICT_EN to use the backward-branch predictor for next PC.
module instr_fetch
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        SYS,
    input  logic        STALL_IN,
    input  logic        REDIRECT_VALID,
    input  logic [31:0] REDIRECT_PC,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_ACK,
    input  logic [31:0] IMEM_RDATA,
    output logic [31:0] Instr_OUT,
    output logic [31:0] Instr_PC_OUT,
    output logic        STALL_OUT
);

    if_state_e   state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ipc_q, ipc_d;
    logic [31:0] tgt_q, tgt_d;
    logic        req_q, req_d;
    logic        stall_q, stall_d;
    logic        sys_q, sys_d;
    logic [31:0] next_pc;
    logic [31:0] redir_pc;
    logic        in_flight;
    logic        unused_redir_lsb;

`ifdef IF_BTFN_PREDICT_EN
    if_btfn_pred u_pred (
        .instr   (instr_q),
        .pc      (ipc_q),
        .next_pc (next_pc)
    );
`else
    assign next_pc = ipc_q + 32'd4;
`endif

    assign redir_pc         = {REDIRECT_PC[31:2], 2'b00};
    assign unused_redir_lsb = ^REDIRECT_PC[1:0];
    // A request still waiting for its ack must be drained, never withdrawn.
    assign in_flight        = req_q && !IMEM_ACK;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        tgt_d   = tgt_q;
        req_d   = req_q;
        stall_d = stall_q;
        sys_d   = sys_q;
        if (REDIRECT_VALID) begin
            stall_d = 1'b1;
            sys_d   = 1'b0;
            if (in_flight) begin
                state_d = ST_DRAIN;
                tgt_d   = redir_pc;
            end else begin
                state_d = ST_REQ;
                addr_d  = redir_pc;
                req_d   = 1'b1;
            end
        end else if (SYS) begin
            stall_d = 1'b1;
            // sys_q marks a drain that ends in HALT instead of a refetch.
            sys_d   = in_flight;
            state_d = in_flight ? ST_DRAIN : ST_HALT;
            req_d   = in_flight;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                end
                ST_REQ: if (IMEM_ACK) begin
                    state_d = ST_VALID;
                    instr_d = IMEM_RDATA;
                    ipc_d   = addr_q;
                    req_d   = 1'b0;
                    stall_d = 1'b0;
                end
                ST_DRAIN: if (IMEM_ACK) begin
                    state_d = sys_q ? ST_HALT : ST_REQ;
                    addr_d  = sys_q ? addr_q : tgt_q;
                    req_d   = !sys_q;
                    sys_d   = 1'b0;
                end
                ST_VALID: if (!STALL_IN) begin
                    state_d = ST_REQ;
                    addr_d  = next_pc;
                    req_d   = 1'b1;
                    stall_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_BOOT;
            addr_q  <= RESET_PC;
            instr_q <= '0;
            ipc_q   <= '0;
            tgt_q   <= '0;
            req_q   <= 1'b0;
            stall_q <= 1'b1;
            sys_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            tgt_q   <= tgt_d;
            req_q   <= req_d;
            stall_q <= stall_d;
            sys_q   <= sys_d;
        end
    end

    assign IMEM_REQ     = req_q;
    assign IMEM_ADDR    = addr_q;
    assign Instr_OUT    = instr_q;
    assign Instr_PC_OUT = ipc_q;
    assign STALL_OUT    = stall_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized self-checking bench for instr_fetch with a memory
// responder and a handoff-level reference model of the fetched PC stream.
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        SYS = 1'b0;
    logic        STALL_IN = 1'b0;
    logic        REDIRECT_VALID = 1'b0;
    logic [31:0] REDIRECT_PC = '0;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_ACK = 1'b0;
    logic [31:0] IMEM_RDATA = '0;
    logic [31:0] Instr_OUT;
    logic [31:0] Instr_PC_OUT;
    logic        STALL_OUT;

    int checks = 0;
    int errors = 0;

    instr_fetch #(.RESET_PC(RST_PC)) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .SYS            (SYS),
        .STALL_IN       (STALL_IN),
        .REDIRECT_VALID (REDIRECT_VALID),
        .REDIRECT_PC    (REDIRECT_PC),
        .IMEM_REQ       (IMEM_REQ),
        .IMEM_ADDR      (IMEM_ADDR),
        .IMEM_ACK       (IMEM_ACK),
        .IMEM_RDATA     (IMEM_RDATA),
        .Instr_OUT      (Instr_OUT),
        .Instr_PC_OUT   (Instr_PC_OUT),
        .STALL_OUT      (STALL_OUT)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0040_0010) return 32'h1000_FFFF;
        return {a[15:0] ^ 16'h5A3C, a[31:16]} ^ 32'h0BAD_C0DE;
    endfunction

    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] ins);
`ifdef IF_BTFN_PREDICT_EN
        logic [31:0] off;
        off = {{16{ins[15]}}, ins[15:0]};
        if ((ins[31:26] == 6'd4 || ins[31:26] == 6'd5) && ins[15]) return pc + 32'd4 + off * 32'd4;
`endif
        return pc + 32'd4;
    endfunction

    // Memory responder: acks each request after a random wait in [wmin, wmax].
    bit mem_en = 1'b1;
    bit pending = 1'b0;
    int wl = 0;
    int wmin = 0;
    int wmax = 0;

    initial forever begin
        @(negedge CLK);
        if (mem_en) begin
            if (RESET || !IMEM_REQ) begin
                IMEM_ACK = 1'b0;
                pending = 1'b0;
            end else begin
                if (!pending) begin
                    pending = 1'b1;
                    wl = $urandom_range(wmax, wmin);
                end
                if (wl == 0) begin
                    IMEM_ACK = 1'b1;
                    IMEM_RDATA = mem_word(IMEM_ADDR);
                    pending = 1'b0;
                end else begin
                    IMEM_ACK = 1'b0;
                    IMEM_RDATA = $urandom;
                    wl--;
                end
            end
        end
    end

    // Reference model: samples 1 ns before each rising edge.
    logic [31:0] exp_pc = RST_PC;
    bit          halted = 1'b0;
    bit          prev_req = 1'b0;
    bit          prev_ack = 1'b0;
    logic [31:0] prev_addr = '0;
    int          cyc = 0;
    int          last_hcyc = -100;
    int          nhand = 0;
    logic [31:0] hq_pc[$];
    logic [31:0] hq_ins[$];
    int          hq_cyc[$];

    always @(negedge CLK) begin
        #4;
        cyc++;
        if (RESET) begin
            exp_pc = RST_PC;
            halted = 1'b0;
            last_hcyc = -100;
            prev_req = 1'b0;
            prev_ack = 1'b0;
        end else begin
            if (prev_req && !prev_ack) begin
                checks++;
                if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== prev_addr) begin
                    errors++;
                    $display("FAIL req_hold req=%b addr=%h expected req=1 addr=%h", IMEM_REQ, IMEM_ADDR, prev_addr);
                end
            end
            if (halted) begin
                checks++;
                if (STALL_OUT !== 1'b1 || IMEM_REQ !== 1'b0 && !prev_req) begin
                    errors++;
                    $display("FAIL halt_state stall=%b req=%b expected stall=1 req=0", STALL_OUT, IMEM_REQ);
                end
            end
            if (REDIRECT_VALID) begin
                exp_pc = {REDIRECT_PC[31:2], 2'b00};
                halted = 1'b0;
            end else if (SYS) begin
                halted = 1'b1;
            end else if (!STALL_OUT && !STALL_IN) begin
                checks++;
                if (halted || Instr_PC_OUT !== exp_pc || Instr_OUT !== mem_word(Instr_PC_OUT)) begin
                    errors++;
                    $display("FAIL handoff pc=%h ins=%h halted=%b expected pc=%h ins=%h", Instr_PC_OUT, Instr_OUT, halted, exp_pc, mem_word(exp_pc));
                end
                checks++;
                if (cyc - last_hcyc < 2) begin
                    errors++;
                    $display("FAIL throughput gap=%0d expected >=2", cyc - last_hcyc);
                end
                hq_pc.push_back(Instr_PC_OUT);
                hq_ins.push_back(Instr_OUT);
                hq_cyc.push_back(cyc);
                nhand++;
                last_hcyc = cyc;
                exp_pc = model_next(Instr_PC_OUT, Instr_OUT);
            end
            prev_req = IMEM_REQ;
            prev_ack = IMEM_ACK;
            prev_addr = IMEM_ADDR;
        end
    end

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b1;
        SYS = 1'b0;
        REDIRECT_VALID = 1'b0;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        hq_pc.delete();
        hq_ins.delete();
        hq_cyc.delete();
    endtask

    task automatic redirect(input logic [31:0] t);
        @(negedge CLK);
        REDIRECT_VALID = 1'b1;
        REDIRECT_PC = t;
        @(negedge CLK);
        REDIRECT_VALID = 1'b0;
    endtask

    task automatic test_reset();
        wmin = 0;
        wmax = 0;
        STALL_IN = 1'b0;
        do_reset();
        repeat (6) @(negedge CLK);
        #2 RESET = 1'b1;
        #1;
        checks++;
        if (IMEM_REQ !== 1'b0 || IMEM_ADDR !== RST_PC) begin
            errors++;
            $display("FAIL reset_imem req=%b addr=%h expected req=0 addr=%h", IMEM_REQ, IMEM_ADDR, RST_PC);
        end
        checks++;
        if (Instr_OUT !== 32'd0 || Instr_PC_OUT !== 32'd0 || STALL_OUT !== 1'b1) begin
            errors++;
            $display("FAIL reset_out ins=%h pc=%h stall=%b expected 0 0 1", Instr_OUT, Instr_PC_OUT, STALL_OUT);
        end
        mem_en = 1'b0;
        IMEM_ACK = 1'b1;
        IMEM_RDATA = 32'hDEAD_BEEF;
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        IMEM_ACK = 1'b0;
        checks++;
        if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== RST_PC) begin
            errors++;
            $display("FAIL boot_req req=%b addr=%h expected req=1 addr=%h", IMEM_REQ, IMEM_ADDR, RST_PC);
        end
        checks++;
        if (STALL_OUT !== 1'b1 || Instr_OUT !== 32'd0 || Instr_PC_OUT !== 32'd0) begin
            errors++;
            $display("FAIL late_ack stall=%b ins=%h pc=%h expected 1 0 0", STALL_OUT, Instr_OUT, Instr_PC_OUT);
        end
        pending = 1'b0;
        mem_en = 1'b1;
    endtask

    task automatic test_seq();
        int n;
        wmin = 0;
        wmax = 0;
        STALL_IN = 1'b0;
        do_reset();
        n = 0;
        while (hq_pc.size() < 3 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (hq_pc.size() < 3) begin
            errors++;
            $display("FAIL seq_timeout handoffs=%0d expected 3", hq_pc.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (hq_pc[i] !== RST_PC + 32'(4 * i)) begin
                    errors++;
                    $display("FAIL seq_pc%0d got %h expected %h", i, hq_pc[i], RST_PC + 32'(4 * i));
                end
            end
            checks++;
            if (hq_cyc[1] - hq_cyc[0] != 2 || hq_cyc[2] - hq_cyc[1] != 2) begin
                errors++;
                $display("FAIL seq_rate gaps %0d %0d expected 2 2", hq_cyc[1] - hq_cyc[0], hq_cyc[2] - hq_cyc[1]);
            end
        end
    endtask

    task automatic test_stall();
        int n;
        logic [31:0] ins, pc;
        STALL_IN = 1'b1;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (STALL_OUT !== 1'b0 && n < 20);
        ins = Instr_OUT;
        pc = Instr_PC_OUT;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            checks++;
            if (Instr_OUT !== ins || Instr_PC_OUT !== pc || STALL_OUT !== 1'b0 || IMEM_REQ !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold ins=%h pc=%h stall=%b req=%b expected %h %h 0 0", Instr_OUT, Instr_PC_OUT, STALL_OUT, IMEM_REQ, ins, pc);
            end
        end
        n = hq_pc.size();
        STALL_IN = 1'b0;
        @(negedge CLK);
        checks++;
        if (hq_pc.size() != n + 1 || STALL_OUT !== 1'b1 || IMEM_REQ !== 1'b1) begin
            errors++;
            $display("FAIL stall_release handoffs=%0d stall=%b req=%b expected %0d 1 1", hq_pc.size(), STALL_OUT, IMEM_REQ, n + 1);
        end else begin
            checks++;
            if (hq_pc[$] !== pc) begin
                errors++;
                $display("FAIL stall_release_pc got %h expected %h", hq_pc[$], pc);
            end
        end
    endtask

    task automatic test_redirect_drain();
        int n;
        wmin = 3;
        wmax = 3;
        STALL_IN = 1'b0;
        do_reset();
        @(negedge CLK);
        checks++;
        if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== RST_PC) begin
            errors++;
            $display("FAIL drain_req req=%b addr=%h expected 1 %h", IMEM_REQ, IMEM_ADDR, RST_PC);
        end
        REDIRECT_VALID = 1'b1;
        REDIRECT_PC = 32'h0040_0103;
        @(negedge CLK);
        REDIRECT_VALID = 1'b0;
        n = 0;
        while (IMEM_ADDR === RST_PC && n < 20) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (IMEM_ADDR !== 32'h0040_0100 || IMEM_REQ !== 1'b1 || hq_pc.size() != 0) begin
            errors++;
            $display("FAIL drain_target addr=%h req=%b handoffs=%0d expected 00400100 1 0", IMEM_ADDR, IMEM_REQ, hq_pc.size());
        end
        n = 0;
        while (hq_pc.size() == 0 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (hq_pc.size() == 0 || hq_pc[0] !== 32'h0040_0100) begin
            errors++;
            $display("FAIL drain_handoff handoffs=%0d expected first pc 00400100", hq_pc.size());
        end
    endtask

    task automatic test_sys();
        int n;
        wmin = 0;
        wmax = 0;
        STALL_IN = 1'b1;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (STALL_OUT !== 1'b0 && n < 20);
        SYS = 1'b1;
        @(negedge CLK);
        SYS = 1'b0;
        checks++;
        if (STALL_OUT !== 1'b1 || IMEM_REQ !== 1'b0) begin
            errors++;
            $display("FAIL sys_flush stall=%b req=%b expected 1 0", STALL_OUT, IMEM_REQ);
        end
        STALL_IN = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            checks++;
            if (STALL_OUT !== 1'b1 || IMEM_REQ !== 1'b0) begin
                errors++;
                $display("FAIL sys_halt stall=%b req=%b expected 1 0", STALL_OUT, IMEM_REQ);
            end
        end
        redirect(32'h8000_0180);
        checks++;
        if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 32'h8000_0180) begin
            errors++;
            $display("FAIL sys_resume req=%b addr=%h expected 1 80000180", IMEM_REQ, IMEM_ADDR);
        end
        hq_pc.delete();
        n = 0;
        while (hq_pc.size() == 0 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (hq_pc.size() == 0 || hq_pc[0] !== 32'h8000_0180) begin
            errors++;
            $display("FAIL sys_resume_handoff handoffs=%0d expected pc 80000180", hq_pc.size());
        end
    endtask

    task automatic test_wrap();
        int n;
        wmin = 1;
        wmax = 1;
        STALL_IN = 1'b0;
        hq_pc.delete();
        redirect(32'hFFFF_FFFC);
        n = 0;
        while (!(hq_pc.size() > 0 && hq_pc[$] === 32'hFFFF_FFFC) && n < 30) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (IMEM_ADDR !== 32'h0000_0000 || IMEM_REQ !== 1'b1) begin
            errors++;
            $display("FAIL wrap addr=%h req=%b expected 00000000 1", IMEM_ADDR, IMEM_REQ);
        end
    endtask

    task automatic test_btfn();
        int n;
        logic [31:0] want;
`ifdef IF_BTFN_PREDICT_EN
        want = 32'h0040_0010;
`else
        want = 32'h0040_0014;
`endif
        wmin = 0;
        wmax = 2;
        STALL_IN = 1'b0;
        hq_pc.delete();
        hq_ins.delete();
        redirect(32'h0040_0010);
        n = 0;
        while (hq_pc.size() == 0 && n < 30) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (hq_pc.size() == 0 || hq_ins[0] !== 32'h1000_FFFF || IMEM_ADDR !== want) begin
            errors++;
            $display("FAIL btfn handoffs=%0d addr=%h expected ins 1000ffff addr=%h", hq_pc.size(), IMEM_ADDR, want);
        end
    endtask

    task automatic test_random();
        int start;
        int r;
        start = nhand;
        wmin = 0;
        wmax = 3;
        for (int i = 0; i < 600; i++) begin
            @(negedge CLK);
            STALL_IN = ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 59);
            REDIRECT_VALID = (r < 2);
            REDIRECT_PC = {$urandom_range(0, 3) == 0 ? 16'hFFFF : 16'h0040, 16'($urandom)};
            SYS = (r == 2);
        end
        @(negedge CLK);
        STALL_IN = 1'b0;
        REDIRECT_VALID = 1'b0;
        SYS = 1'b0;
        checks++;
        if (nhand - start < 20) begin
            errors++;
            $display("FAIL random_progress handoffs=%0d expected >=20", nhand - start);
        end
    endtask

    initial begin
        test_reset();
        test_seq();
        test_stall();
        test_redirect_drain();
        test_sys();
        test_wrap();
        test_btfn();
        test_random();
        repeat (2) @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

endmodule
